hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
// - Pipeline sequencing controller for the 5-stage rv32i core; sits beside the EX forwarding unit.
// - Resolves hazards the forwarding unit cannot: load-use (one bubble), I/D memory stalls (global freeze), taken branch/jump (flush).
// - Drives pipeline-register load enables, bubble and flush controls; keeps saturating perf counters and a memory-stall watchdog.
// PARAMETERS
// CNT_W     32    width of each perf counter (stall_cnt, bubble_cnt, flush_cnt)
// WD_CYCLES 1024  consecutive MEM_WAIT cycles after which wd_err sets; must be >= 2
// PORTS
// clk          in   1   core clock
// rst          in   1   asynchronous, active-high reset
// id_rs1       in   5   rs1 field of instruction in ID
// id_rs2       in   5   rs2 field of instruction in ID
// id_uses_rs1  in   1   ID instruction reads rs1
// id_uses_rs2  in   1   ID instruction reads rs2
// ex_is_load   in   1   instruction in EX is a load (op_load)
// ex_rd        in   5   destination reg of instruction in EX
// ex_br_taken  in   1   EX branch/jal/jalr redirects PC this cycle
// imem_req     in   1   fetch request outstanding
// imem_resp    in   1   fetch data valid this cycle
// dmem_req     in   1   MEM-stage load/store outstanding
// dmem_resp    in   1   data access complete this cycle
// pc_load      out  1   PC register enable
// if_id_load   out  1   IF/ID enable
// id_ex_load   out  1   ID/EX enable
// ex_mem_load  out  1   EX/MEM enable
// mem_wb_load  out  1   MEM/WB enable
// id_ex_bubble out  1   write NOP control word into ID/EX (valid only with id_ex_load)
// if_id_flush  out  1   write NOP into IF/ID (valid only with if_id_load)
// stall_cnt    out  CNT_W  cycles spent frozen on memory
// bubble_cnt   out  CNT_W  load-use bubbles inserted
// flush_cnt    out  CNT_W  branch flushes performed
// wd_err       out  1   sticky: memory stall exceeded WD_CYCLES
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
// - Decodes (combinational):
//   - mem_busy = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp)
//   - load_use = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
// - Priority each cycle: mem_busy > ex_br_taken > load_use > normal. Outputs are combinational from state and inputs.
// - FREEZE (mem_busy): all five enables 0, bubble/flush 0.
// - FLUSH (ex_br_taken & ~mem_busy): all enables 1, if_id_flush=1, id_ex_bubble=1, flush_cnt++. Overrides load_use.
// - BUBBLE (load_use & ~mem_busy & ~ex_br_taken & state!=BUBBLE): pc_load=0, if_id_load=0; id_ex_load=1, id_ex_bubble=1, ex_mem_load=1, mem_wb_load=1; bubble_cnt++.
// - NORMAL: all enables 1, bubble/flush 0.
// - FSM states (registered): RUN, MEM_WAIT, BUBBLE.
//   - Any state with mem_busy -> MEM_WAIT.
//   - Otherwise: BUBBLE action taken -> BUBBLE; else -> RUN.
//   - In BUBBLE, load_use is ignored, so a second consecutive bubble is never inserted. EX holds a NOP there, so load_use=1 in BUBBLE is a checker error.
// - stall_cnt increments in every FREEZE cycle.
// - wait_ctr:
//   - counts consecutive MEM_WAIT cycles; clears on any cycle in which the next state is not MEM_WAIT;
//   - sets wd_err when it reaches WD_CYCLES; wd_err stays 1 until rst.
//   - Freeze behaviour is unchanged by wd_err.
// - Counters saturate at all-ones and never wrap. Counter increments are gated off while rst is high.
// - Reset (any time, including mid-stall):
//   - state=RUN, all counters=0, wait_ctr=0, wd_err=0.
//   - While rst=1, all five load enables, id_ex_bubble and if_id_flush are 0.
//   - First cycle after release is evaluated from state RUN.
// - Simultaneous imem and dmem stalls: freeze lasts until both have responded; one stall_cnt increment per frozen cycle.
// - A branch that is in EX during a freeze is held there and flushes in the first unfrozen cycle.
// TESTING
// - lw x5 in EX, ID add x6,x5,x1 (uses rs1=5) -> one cycle: pc_load=0, id_ex_bubble=1; next cycle state=BUBBLE, all enables 1; bubble_cnt=1.
// - lw x0 in EX, ID reads x0; or ID reads x5 with id_uses_rs1=0 -> no bubble, all enables 1.
// - dmem_req=1, dmem_resp=0 for 3 cycles, ex_br_taken=1 throughout -> 3 frozen cycles (stall_cnt=3); on the resp cycle if_id_flush=1, flush_cnt=1.
// - ex_br_taken=1 with load_use=1, no mem stall -> FLUSH only: bubble_cnt unchanged, pc_load=1.
// - WD_CYCLES=4, imem_resp held 0 -> wd_err=1 after 4th MEM_WAIT cycle; stays 1 after resp; clears only on rst.
// - rst pulsed mid-MEM_WAIT -> outputs/counters 0 immediately (async); RUN after release. CNT_W=3 with 9 flushes -> flush_cnt=7.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage rv32i core: resolves load-use,
// memory-stall and taken-branch hazards, and keeps perf counters plus a stall watchdog.
module hazard_stall_ctrl #(
   parameter int CNT_W     = 32,
   parameter int WD_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_rd,
   input  logic             ex_br_taken,
   input  logic             imem_req,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             id_ex_load,
   output logic             ex_mem_load,
   output logic             mem_wb_load,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             wd_err
);

   localparam int               WAIT_W   = $clog2(WD_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WD_CYCLES);
   localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(WD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_BUBBLE   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_mem_busy;
   logic              w_rs1_hit;
   logic              w_rs2_hit;
   logic              w_load_use;
   logic              w_do_flush;
   logic              w_do_bubble;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_bubble_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;
   logic [WAIT_W-1:0] r_wait_ctr;
   logic              r_wd_err;

   // Hazard decodes; the action priority is freeze > flush > bubble > run.
   assign w_mem_busy  = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);
   assign w_rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd);
   assign w_rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd);
   assign w_load_use  = ex_is_load & (ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);
   assign w_do_flush  = ~w_mem_busy & ex_br_taken;
   assign w_do_bubble = ~w_mem_busy & ~ex_br_taken & w_load_use & (r_state != ST_BUBBLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = ST_RUN;
      if (w_mem_busy) begin
         w_next_state = ST_MEM_WAIT;
      end else if (w_do_bubble) begin
         w_next_state = ST_BUBBLE;
      end
   end

   always_comb begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      if (!rst && !w_mem_busy) begin
         id_ex_load  = 1'b1;
         ex_mem_load = 1'b1;
         mem_wb_load = 1'b1;
         if (w_do_flush) begin
            pc_load      = 1'b1;
            if_id_load   = 1'b1;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
         end else if (w_do_bubble) begin
            id_ex_bubble = 1'b1;
         end else begin
            pc_load    = 1'b1;
            if_id_load = 1'b1;
         end
      end
   end

   // Perf counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if (w_mem_busy && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_do_bubble && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         end
         if (w_do_flush && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   // Watchdog: wd_err trips on the cycle the consecutive-freeze count reaches WD_CYCLES.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_ctr <= '0;
         r_wd_err   <= 1'b0;
      end else if (w_next_state == ST_MEM_WAIT) begin
         if (r_wait_ctr != WAIT_MAX) begin
            r_wait_ctr <= r_wait_ctr + 1'b1;
         end
         if (r_wait_ctr == WAIT_TRIP) begin
            r_wd_err <= 1'b1;
         end
      end else begin
         r_wait_ctr <= '0;
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
   assign flush_cnt  = r_flush_cnt;
   assign wd_err     = r_wd_err;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a driver pushes model-predicted outputs per cycle,
// a monitor pops and compares them on the falling edge.
module tb_hazard_stall_ctrl;

   localparam int CNT_W  = 3;
   localparam int WD     = 4;
   localparam int CNT_MX = (1 << CNT_W) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_br_taken;
   logic       imem_req, imem_resp, dmem_req, dmem_resp;
   logic       pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
   logic       id_ex_bubble, if_id_flush, wd_err;
   logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

   hazard_stall_ctrl #(.CNT_W(CNT_W), .WD_CYCLES(WD)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
      .imem_req(imem_req), .imem_resp(imem_resp),
      .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
      .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
      .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
      .wd_err(wd_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] ctrl;  // pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush
      logic [9:0] cnt;   // stall, bubble, flush, wd_err
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   ncyc  = 0;

   // Reference model: plain integer counters and a "last cycle was a bubble" flag.
   int m_stall = 0, m_bub = 0, m_flush = 0, m_wait = 0;
   bit m_wd = 0, m_prev_bub = 0;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d actual=%b required=%b", name, ncyc, got, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic ld, input logic [4:0] rd,
                      input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                      input logic br, input logic ireq, input logic iresp,
                      input logic dreq, input logic dresp);
      exp_t e;
      bit   busy, lu, do_bub;
      rst = r; ex_is_load = ld; ex_rd = rd; id_rs1 = a1; id_uses_rs1 = u1;
      id_rs2 = a2; id_uses_rs2 = u2; ex_br_taken = br;
      imem_req = ireq; imem_resp = iresp; dmem_req = dreq; dmem_resp = dresp;
      busy = (ireq && !iresp) || (dreq && !dresp);
      lu   = ld && (rd != 0) && ((u1 && a1 == rd) || (u2 && a2 == rd));
      e    = '0;
      if (r) begin
         m_stall = 0; m_bub = 0; m_flush = 0; m_wait = 0; m_wd = 0; m_prev_bub = 0;
      end else begin
         e.cnt  = {3'(m_stall), 3'(m_bub), 3'(m_flush), m_wd};
         do_bub = 0;
         if (busy)                  e.ctrl = 7'b0000000;
         else if (br)               e.ctrl = 7'b1111111;
         else if (lu && !m_prev_bub) begin
            e.ctrl = 7'b0011110;
            do_bub = 1;
         end else                   e.ctrl = 7'b1111100;
         if (busy) begin
            if (m_stall < CNT_MX) m_stall++;
            m_wait++;
            if (m_wait >= WD) m_wd = 1;
         end else begin
            m_wait = 0;
            if (br && m_flush < CNT_MX) m_flush++;
            if (do_bub && m_bub < CNT_MX) m_bub++;
         end
         m_prev_bub = do_bub;
      end
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compare every presented cycle against the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("ctrl", 16'({pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                               id_ex_bubble, if_id_flush}), 16'(e.ctrl));
            check("counters", 16'({stall_cnt, bubble_cnt, flush_cnt, wd_err}), 16'(e.cnt));
            ncyc++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; ex_br_taken = 0;
      imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
      @(posedge clk);
      #1;
      do_reset();
      idle(1);

      // Load-use bubble, then BUBBLE state ignores the same hazard.
      cyc(0, 1, 5, 5, 1, 1, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 5, 5, 1, 1, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 6, 1, 1, 1, 0, 0, 0, 0, 0);
      // No hazard: load to x0, or unused rs1 / rs2 hazard only.
      cyc(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 5, 5, 0, 1, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 7, 2, 1, 7, 1, 0, 0, 0, 0, 0);

      // Branch held in EX across a 3-cycle dmem stall, flushes on the response.
      do_reset();
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
      idle(1);
      // Branch overrides load-use.
      cyc(0, 1, 5, 5, 1, 0, 0, 1, 0, 0, 0, 0);
      idle(1);
      // Simultaneous imem and dmem stalls, released one at a time.
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

      // Watchdog: imem stalled past WD cycles, sticky after response.
      do_reset();
      for (int i = 0; i < WD + 2; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      idle(2);
      // Short stall below the threshold after reset does not trip it.
      do_reset();
      for (int i = 0; i < WD - 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idle(1);
      for (int i = 0; i < WD - 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idle(1);

      // Reset asserted mid-stall, evaluated from RUN after release.
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(1, 1, 5, 5, 1, 0, 0, 1, 0, 0, 1, 0);
      cyc(0, 1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // Flush counter saturation: 9 flushes on a 3-bit counter.
      do_reset();
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(1);

      // Randomised traffic with small register indices to make hazards frequent.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic ireq, dreq;
         ireq = ($urandom_range(0, 1) == 1);
         dreq = ($urandom_range(0, 2) == 0);
         cyc(($urandom_range(0, 79) == 0),
             ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
             5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 5) == 0),
             ireq, ireq && ($urandom_range(0, 4) < 3),
             dreq, dreq && ($urandom_range(0, 4) < 2));
      end

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
